// File: rtl/vga_reg_commit_ctrl_if.sv
// Register-bus bundle for vga_reg_commit_ctrl.
// Carries the host Avalon-style write port, the game engine req/gnt write
// port, and the registered write port to the display block.
//   slave  : the commit controller (takes host/game writes, drives out_*)
//   master : the surrounding system (drives host/game, sees gnt and out_*)
interface vga_reg_commit_ctrl_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          host_chipselect;
  logic          host_write;
  logic [AW-1:0] host_address;
  logic [DW-1:0] host_writedata;
  logic          game_req;
  logic [AW-1:0] game_address;
  logic [DW-1:0] game_writedata;
  logic          game_gnt;
  logic          out_chipselect;
  logic          out_write;
  logic [AW-1:0] out_address;
  logic [DW-1:0] out_writedata;

  modport slave (
    input  host_chipselect, host_write, host_address, host_writedata,
    input  game_req, game_address, game_writedata,
    output game_gnt,
    output out_chipselect, out_write, out_address, out_writedata
  );

  modport master (
    output host_chipselect, host_write, host_address, host_writedata,
    output game_req, game_address, game_writedata,
    input  game_gnt,
    input  out_chipselect, out_write, out_address, out_writedata
  );
endinterface

// File: rtl/vga_reg_commit_ctrl.sv
// Frame-synchronous register commit controller.
// Host and game engine write into a shadow register file; changed registers
// are flushed to the display block only after vblank_start, one index per
// cycle, so sprite positions never change mid-frame.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   bus (slave)    : host write port, game req/gnt port, display write port
//   vblank_start   : one-cycle pulse at the start of vertical blank
//   busy           : commit scan in progress
//   overrun        : sticky, vblank_start seen while a scan was running
//   commit_count   : completed scans, wrapping 16-bit counter
// Build option: define VRC_FORCE_ALL_EN to emit every register every frame
// instead of only the dirty ones.
module vga_reg_commit_ctrl #(
  parameter int NREGS = 13,
  parameter int AW    = 9,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_reg_commit_ctrl_if.slave bus,
  input  logic                 vblank_start,
  output logic                 busy,
  output logic                 overrun,
  output logic [15:0]          commit_count
);
  localparam int IW = $clog2(NREGS);
`ifdef VRC_FORCE_ALL_EN
  localparam bit FORCE_ALL = 1'b1;
`else
  localparam bit FORCE_ALL = 1'b0;
`endif

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                   state, state_nxt;
  logic [IW-1:0]            idx, idx_nxt;
  logic [NREGS-1:0][DW-1:0] shadow;
  logic [NREGS-1:0]         dirty;

  // Host has fixed priority and never stalls; a losing game request simply
  // stays asserted and is granted on a later cycle.
  logic          host_we, wr_hit, scan_last, emit;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  assign host_we      = bus.host_chipselect & bus.host_write;
  assign bus.game_gnt = bus.game_req & ~host_we;
  assign wr_addr      = host_we ? bus.host_address   : bus.game_address;
  assign wr_data      = host_we ? bus.host_writedata : bus.game_writedata;
  // Out-of-range addresses are accepted (game still granted) but dropped.
  assign wr_hit       = (host_we | bus.game_gnt) && (wr_addr < AW'(NREGS));
  assign scan_last    = (idx == IW'(NREGS - 1));
  assign busy         = (state == SCAN);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic; vblank_start during SCAN does not restart the scan.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (vblank_start) begin
        state_nxt = SCAN;
        idx_nxt   = '0;
      end
      SCAN: if (scan_last) state_nxt = IDLE;
            else           idx_nxt   = idx + 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: which index (if any) goes out this cycle.
  always_comb begin
    emit = 1'b0;
    if (state == SCAN) emit = dirty[idx] | FORCE_ALL;
  end

  // Shadow file and dirty bits. The write's set is assigned after the scan's
  // clear so a same-cycle write to the emitted index keeps it dirty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      dirty  <= '0;
    end else begin
      if (state == SCAN) dirty[idx] <= 1'b0;
      if (wr_hit) begin
        shadow[wr_addr[IW-1:0]] <= wr_data;
        dirty[wr_addr[IW-1:0]]  <= 1'b1;
      end
    end
  end

  // Registered display-side write port and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_chipselect <= 1'b0;
      bus.out_write      <= 1'b0;
      bus.out_address    <= '0;
      bus.out_writedata  <= '0;
      overrun            <= 1'b0;
      commit_count       <= '0;
    end else begin
      bus.out_chipselect <= emit;
      bus.out_write      <= emit;
      if (emit) begin
        bus.out_address   <= AW'(idx);
        bus.out_writedata <= shadow[idx];
      end
      if (state == SCAN && vblank_start) overrun <= 1'b1;
      if (state == SCAN && scan_last) commit_count <= commit_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_vga_reg_commit_ctrl.sv
// Self-checking bench for vga_reg_commit_ctrl: directed frame scenarios plus
// randomized host/game/vblank traffic, compared every cycle against a
// behavioural model of the shadow file and commit scan.
module tb_vga_reg_commit_ctrl;
  localparam int NREGS = 13;
  localparam int AW    = 9;
  localparam int DW    = 32;
`ifdef VRC_FORCE_ALL_EN
  localparam bit FORCE_ALL = 1'b1;
`else
  localparam bit FORCE_ALL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vb = 1'b0;
  logic        busy, overrun;
  logic [15:0] commit_count;
  logic          hc = 0, hw = 0, gr = 0;
  logic [AW-1:0] ha = '0, ga = '0;
  logic [DW-1:0] hd = '0, gd = '0;
  logic          g_took;

  vga_reg_commit_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  assign bus.host_chipselect = hc;
  assign bus.host_write      = hw;
  assign bus.host_address    = ha;
  assign bus.host_writedata  = hd;
  assign bus.game_req        = gr;
  assign bus.game_address    = ga;
  assign bus.game_writedata  = gd;

  vga_reg_commit_ctrl #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .vblank_start(vb),
    .busy(busy), .overrun(overrun), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a frame commit walks the registers in order, one per
  // cycle, emitting the pre-write value of each dirty one.
  logic [DW-1:0] m_shadow [NREGS];
  bit            m_dirty  [NREGS];
  bit            m_scan, m_ovr, m_wr;
  int            m_pos;
  logic [15:0]   m_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) begin m_shadow[i] = '0; m_dirty[i] = 0; end
    m_scan = 0; m_ovr = 0; m_wr = 0; m_pos = 0; m_cnt = '0; m_addr = '0; m_data = '0;
  endfunction

  function automatic void model_step();
    bit            hwe = hc & hw;
    bit            gwe = gr & !hwe;
    logic [AW-1:0] wa  = hwe ? ha : ga;
    logic [DW-1:0] wd  = hwe ? hd : gd;
    bit            was_scan = m_scan;
    m_wr = 0;
    if (was_scan) begin
      if (m_dirty[m_pos] || FORCE_ALL) begin
        m_wr = 1; m_addr = AW'(m_pos); m_data = m_shadow[m_pos];
      end
      m_dirty[m_pos] = 0;
      if (m_pos == NREGS - 1) begin m_scan = 0; m_cnt = m_cnt + 16'd1; end
      else m_pos++;
    end
    if (vb) begin
      if (was_scan) m_ovr = 1;
      else begin m_scan = 1; m_pos = 0; end
    end
    if ((hwe || gwe) && int'(wa) < NREGS) begin
      m_shadow[wa] = wd; m_dirty[wa] = 1;
    end
  endfunction

  task automatic cmp_outputs(input string pfx);
    chk({pfx, "out_write"}, bus.out_write, m_wr);
    chk({pfx, "out_cs"},    bus.out_chipselect, m_wr);
    chk({pfx, "out_addr"},  bus.out_address, m_addr);
    chk({pfx, "out_data"},  bus.out_writedata, m_data);
    chk({pfx, "busy"},      busy, m_scan);
    chk({pfx, "overrun"},   overrun, m_ovr);
    chk({pfx, "count"},     commit_count, m_cnt);
  endtask

  // One clock: inputs are set at the negedge before the call. Host writes and
  // vblank are single-cycle; a game request is held until granted.
  task automatic step();
    #1 chk("game_gnt", bus.game_gnt, gr & ~(hc & hw));
    g_took = gr & ~(hc & hw);
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_outputs("");
    if (g_took) gr = 0;
    hc = 0; hw = 0; vb = 0;
  endtask

  task automatic host_wr(input int a, input logic [DW-1:0] d);
    hc = 1; hw = 1; ha = AW'(a); hd = d;
  endtask

  task automatic frame(input int extra);
    vb = 1; step();
    repeat (NREGS + extra) step();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(negedge clk);
    cmp_outputs("rst_");
    @(negedge clk);
    reset = 0;

    // Two host writes, one frame: addr1 and addr10 only.
    host_wr(1, 32'h40); step();
    host_wr(10, 32'h7); step();
    frame(1);
    chk("cnt_after_f1", commit_count, 32'd1);

    // Empty frame still takes a full scan and counts.
    frame(1);
    chk("cnt_after_f2", commit_count, 32'd2);

    // Host and game in the same cycle: game deferred one cycle.
    host_wr(5, 32'h11); gr = 1; ga = 9'd6; gd = 32'h22; step();
    chk("game_deferred", gr, 32'd1);
    step();
    frame(1);

    // Writes during scan: addr9 ahead of idx, addr3 behind it.
    vb = 1; step();
    repeat (8) step();
    host_wr(9, 32'h66); step();
    host_wr(3, 32'h55); step();
    repeat (4) step();
    frame(1);

    // Same-index write while it is emitted: old value out, stays dirty.
    host_wr(4, 32'hA1); step();
    vb = 1; step();
    repeat (4) step();
    host_wr(4, 32'hB2); step();
    repeat (8) step();
    frame(1);

    // Second vblank five cycles into a scan.
    vb = 1; step();
    repeat (4) step();
    vb = 1; step();
    repeat (10) step();
    chk("overrun_set", overrun, 32'd1);

    // Out-of-range write, then reset in the middle of a scan.
    host_wr(20, 32'hFF); step();
    gr = 1; ga = 9'd17; gd = 32'h3; step();
    host_wr(2, 32'h9); step();
    vb = 1; step();
    repeat (6) step();
    reset = 1;
    model_reset();
    #1 cmp_outputs("midrst_");
    chk("midrst_cnt0", commit_count, 32'd0);
    @(negedge clk);
    reset = 0;
    repeat (3) step();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      if (!gr && $urandom_range(0, 3) == 0) begin
        gr = 1; gd = $urandom;
        ga = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(13, 40)) : AW'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 2) == 0) begin
        hc = 1; hw = ($urandom_range(0, 5) != 0); hd = $urandom;
        ha = ($urandom_range(0, 4) == 0) ? ga : AW'($urandom_range(0, 15));
      end
      vb = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
